// File: rtl/piped_skid_if.sv
// rtl/piped_skid_if.sv - ready/valid handshake bundle for the piped_skid stage
interface piped_skid_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   // master drives words in and accepts them out; slave is the stage itself
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/piped_skid.sv
// rtl/piped_skid.sv - registered pipe stage with 2-entry skid buffer
// Backpressure reaches in_ready from state only, never combinationally from out_ready.
module piped_skid #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   piped_skid_if.slave      bus,
   input  logic             flush,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_count
);
   // state encoding doubles as the occupancy count
   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] BUSY  = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] main_data_q, main_data_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic main_v;
   logic accept;
   logic emit;

   assign main_v        = (state_q != EMPTY);
   assign bus.in_ready  = ~rst & (state_q != FULL);
   assign bus.out_valid = main_v;
   assign bus.out_data  = main_data_q;
   assign occupancy     = state_q;
   assign stall_count   = stall_q;

   assign accept = bus.in_valid & bus.in_ready;
   assign emit   = main_v & bus.out_ready;

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      skid_data_d = skid_data_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d     = BUSY;
               main_data_d = bus.in_data;
            end
         end
         BUSY: begin
            if (accept && emit) begin
               main_data_d = bus.in_data;
            end else if (accept) begin
               state_d     = FULL;
               skid_data_d = bus.in_data;
            end else if (emit) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (emit) begin
               state_d     = BUSY;
               main_data_d = skid_data_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      // flush wins over any accept or emit in the same cycle
      if (flush) begin
         state_d     = EMPTY;
         main_data_d = main_data_q;
         skid_data_d = skid_data_q;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (main_v && !bus.out_ready && (stall_q != CNT_MAX)) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         main_data_q <= '0;
         skid_data_q <= '0;
         stall_q     <= '0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         skid_data_q <= skid_data_d;
         stall_q     <= stall_d;
      end
   end
endmodule

// File: tb/tb_piped_skid.sv
// tb/tb_piped_skid.sv - directed and random self-checking bench for piped_skid
module tb_piped_skid;
   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        sat_flush;
   logic [1:0]  occupancy;
   logic [1:0]  sat_occupancy;
   logic [15:0] stall_count;
   logic [3:0]  sat_stall_count;

   int n_checks = 0;
   int n_fail   = 0;

   piped_skid_if #(.WIDTH(32)) bus ();
   piped_skid_if #(.WIDTH(32)) sat_bus ();

   piped_skid #(.WIDTH(32), .CNT_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .flush       (flush),
      .occupancy   (occupancy),
      .stall_count (stall_count)
   );

   piped_skid #(.WIDTH(32), .CNT_W(4)) sat (
      .clk         (clk),
      .rst         (rst),
      .bus         (sat_bus),
      .flush       (sat_flush),
      .occupancy   (sat_occupancy),
      .stall_count (sat_stall_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] exp_q[$];
   logic [31:0] word;
   logic [31:0] got_data;
   logic [31:0] exp_data;
   logic        acc;
   logic        emt;

   initial begin
      rst               = 1'b1;
      flush             = 1'b0;
      sat_flush         = 1'b0;
      bus.in_valid      = 1'b1;
      bus.in_data       = 32'hDEAD_BEEF;
      bus.out_ready     = 1'b0;
      sat_bus.in_valid  = 1'b0;
      sat_bus.in_data   = 32'h0;
      sat_bus.out_ready = 1'b0;

      // reset with a word presented
      #1;
      check("rst_in_ready_comb", {31'b0, bus.in_ready}, 32'h0);
      tick();
      tick();
      check("rst_in_ready", {31'b0, bus.in_ready}, 32'h0);
      check("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
      check("rst_out_data", bus.out_data, 32'h0);
      check("rst_occupancy", {30'b0, occupancy}, 32'h0);
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      check("post_rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
      check("post_rst_stall", {16'b0, stall_count}, 32'h0);

      // streaming at full rate
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         bus.in_data = i;
         tick();
         check("stream_data", bus.out_data, i);
         check("stream_valid", {31'b0, bus.out_valid}, 32'h1);
         check("stream_in_ready", {31'b0, bus.in_ready}, 32'h1);
      end
      bus.in_valid = 1'b0;
      tick();
      check("stream_drain_valid", {31'b0, bus.out_valid}, 32'h0);
      check("stream_stall", {16'b0, stall_count}, 32'h0);

      // skid fill, one extra held cycle in FULL
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'hA;
      tick();
      check("skid_occ1", {30'b0, occupancy}, 32'h1);
      check("skid_data_a", bus.out_data, 32'hA);
      bus.in_data = 32'hB;
      tick();
      check("skid_occ2", {30'b0, occupancy}, 32'h2);
      check("skid_in_ready", {31'b0, bus.in_ready}, 32'h0);
      check("skid_hold_a", bus.out_data, 32'hA);
      bus.in_valid = 1'b0;
      tick();
      check("skid_stable_occ", {30'b0, occupancy}, 32'h2);
      check("skid_stable_a", bus.out_data, 32'hA);
      bus.out_ready = 1'b1;
      tick();
      check("skid_emit_b", bus.out_data, 32'hB);
      check("skid_occ_back1", {30'b0, occupancy}, 32'h1);
      check("skid_in_ready_back", {31'b0, bus.in_ready}, 32'h1);
      tick();
      check("skid_occ0", {30'b0, occupancy}, 32'h0);
      check("skid_stall", {16'b0, stall_count}, 32'h2);

      // flush while FULL drops held and presented words, keeps stall count
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'h10;
      tick();
      bus.in_data = 32'h20;
      tick();
      check("flush_pre_occ", {30'b0, occupancy}, 32'h2);
      flush       = 1'b1;
      bus.in_data = 32'h30;
      tick();
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      check("flush_occ", {30'b0, occupancy}, 32'h0);
      check("flush_valid", {31'b0, bus.out_valid}, 32'h0);
      check("flush_in_ready", {31'b0, bus.in_ready}, 32'h1);
      check("flush_stall_kept", {16'b0, stall_count}, 32'h4);
      bus.out_ready = 1'b1;
      tick();
      check("flush_no_30", {31'b0, bus.out_valid}, 32'h0);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h40;
      tick();
      check("flush_next_word", bus.out_data, 32'h40);
      bus.in_valid = 1'b0;
      tick();

      // reset while FULL discards everything
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'h55;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      check("rst_full_occ", {30'b0, occupancy}, 32'h0);
      check("rst_full_stall", {16'b0, stall_count}, 32'h0);
      check("rst_full_data", bus.out_data, 32'h0);

      // saturation on the 4-bit counter instance
      sat_bus.in_valid = 1'b1;
      sat_bus.in_data  = 32'h5;
      tick();
      sat_bus.in_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("sat_mid", {28'b0, sat_stall_count}, 32'd10);
      for (int i = 0; i < 20; i++) tick();
      check("sat_top", {28'b0, sat_stall_count}, 32'hF);
      check("sat_data_held", sat_bus.out_data, 32'h5);

      // random handshakes against a FIFO model
      flush = 1'b1;
      tick();
      flush = 1'b0;
      word  = 32'h1234_5678;
      for (int i = 0; i < 10000; i++) begin
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.out_ready = 1'($urandom_range(0, 1));
         bus.in_data   = word;
         acc      = bus.in_valid & bus.in_ready;
         emt      = bus.out_valid & bus.out_ready;
         got_data = bus.out_data;
         tick();
         if (emt) begin
            if (exp_q.size() == 0) begin
               check("rand_spurious", 32'h1, 32'h0);
            end else begin
               exp_data = exp_q.pop_front();
               check("rand_data", got_data, exp_data);
            end
         end
         if (acc) begin
            exp_q.push_back(word);
            word = word * 32'h9E37_79B9 + 32'h1;
         end
         check("rand_occ", {30'b0, occupancy}, exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
